// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int DEF_DATA_W = 14;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DEPTH  = 144;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: under contention the requester not granted last wins.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = 2'b00;
        if (req_a && req_b) begin
            grant = (last_grant == REQ_A) ? 2'b10 : 2'b01;
        end else if (req_a) begin
            grant = 2'b01;
        end else if (req_b) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer giving requesters A and B alternating access
// to a single-port RAM with combinational read data; rejects addresses >= DEPTH.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic              we_q;
    logic              oor_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        grant;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    rr_arb2 u_rr_arb2 (
        .req_a      (a_req),
        .req_b      (b_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel_we       = grant[1] ? b_we    : a_we;
    assign sel_addr     = grant[1] ? b_addr  : a_addr;
    assign sel_wdata    = grant[1] ? b_wdata : a_wdata;
    assign sel_in_range = (sel_addr <= LAST_ADDR);

    // The RAM port is driven straight from the command registers so it holds while idle.
    assign ram_address = addr_q;
    assign ram_data    = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= REQ_A;
            last_grant <= REQ_B;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            ram_wren   <= 1'b0;
            ram_rden   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner    <= grant[1] ? REQ_B : REQ_A;
                        we_q     <= sel_we;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        oor_q    <= !sel_in_range;
                        a_ack    <= grant[0];
                        b_ack    <= grant[1];
                        ram_wren <= sel_in_range && sel_we;
                        ram_rden <= sel_in_range && !sel_we;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_wren   <= 1'b0;
                    ram_rden   <= 1'b0;
                    busy       <= 1'b0;
                    last_grant <= owner;
                    err        <= oor_q;
                    if (!we_q) begin
                        if (owner == REQ_B) begin
                            b_rvalid <= 1'b1;
                            b_rdata  <= oor_q ? '0 : ram_q;
                        end else begin
                            a_rvalid <= 1'b1;
                            a_rdata  <= oor_q ? '0 : ram_q;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port `ram` block (DATA_W 14, ADDR_W 12).
- Requester A (instruction fetch) and requester B (data/loader) each issue read/write commands on a req/ack handshake.
- Grants one command at a time with round-robin fairness, registers the command, and drives the RAM's data/address/wren/rden.
- The RAM's read output is combinational; the arbiter captures it and returns it to the owning requester with a valid pulse.
- Rejects out-of-range addresses.

Parameters:
- DATA_W, 14, data word width; must match the RAM.
- ADDR_W, 12, address width; must match the RAM.
- DEPTH, 144, number of implemented RAM words; addresses >= DEPTH are rejected.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A command pending; held with fields stable until a_ack
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  requester A address
- a_wdata  in  DATA_W  requester A write data
- a_ack  out  1  one-cycle pulse: command A accepted
- a_rvalid  out  1  one-cycle pulse: a_rdata valid (reads only)
- a_rdata  out  DATA_W  read data for A
- b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as A, for requester B
- ram_data  out  DATA_W  to RAM data
- ram_address  out  ADDR_W  to RAM address
- ram_wren  out  1  to RAM wren
- ram_rden  out  1  to RAM rden
- ram_q  in  DATA_W  from RAM q
- busy  out  1  high while in ACCESS
- err  out  1  one-cycle pulse: out-of-range command completed (no RAM access)

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: all outputs 0, state = IDLE, last_grant = B (so A wins the first tie), command registers 0.
- FSM states:
  - IDLE: if any req is high, choose a winner. Latch owner, we, addr and wdata. Pulse the winner's ack in the next cycle. Go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive ram_address and ram_data from the registers, plus exactly one of ram_wren / ram_rden. On the closing posedge, a write commits and ram_q is captured into the owner's rdata. Update last_grant = owner. Return to IDLE.
- Arbitration:
  - Single request: that requester wins.
  - Both requesting: the requester not equal to last_grant wins (strict alternation under contention).
  - No requester waits more than one command.
- Timing, with req sampled at the posedge ending cycle N:
  - N+1: ack pulse, busy = 1, RAM strobed.
  - N+2: rvalid pulse with rdata (reads); state is IDLE and may accept the next command.
  - Throughput: one command per 2 cycles; read latency is 2 cycles from acceptance.
- Handshake rules:
  - req is not sampled in ACCESS.
  - A requester drops req on the posedge after seeing ack. A req still high in N+2 is a new command.
- rdata holds its value until that requester's next read completes.
- ram_wren and ram_rden are never both 1. Both are 0 in IDLE.
- ram_data and ram_address hold the last command's values while idle.
- Out-of-range (addr >= DEPTH):
  - Command is accepted (ack pulses) but ram_wren = ram_rden = 0 in ACCESS.
  - err pulses in N+2.
  - For reads, rvalid also pulses in N+2 with rdata = 0.
- Boundaries:
  - addr = DEPTH-1 is accepted normally.
  - Simultaneous a_req/b_req every cycle gives grants A,B,A,B…
- Reset mid-ACCESS: ram_wren and ram_rden drop immediately. A write whose posedge has not occurred is lost. No ack, rvalid or err pulse follows reset.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, ACCESS}
  - requester ID constants REQ_A = 0, REQ_B = 1
  - default width constants
- Sub-module rr_arb2: 2-way round-robin grant. Inputs: two reqs and last_grant. Output: one-hot grant; combinational.

Test Plan:
1. A writes 0x1ABC to addr 5, then A reads addr 5 -> ack in N+1, ram_wren = 1 for one cycle; on the read, a_rvalid = 1 with a_rdata = 0x1ABC in N+2; b_rvalid stays 0.
2. a_req and b_req held from reset, A reading addr 1, B reading addr 2 -> grant order A,B,A,B; ack pulses 2 cycles apart; each rdata matches the preloaded RAM contents.
3. B reads addr 143 then addr 144 (DEPTH = 144) -> addr 143 returns the RAM word with err = 0; addr 144 gives ack, no ram_rden, err = 1 and b_rvalid = 1 with b_rdata = 0 in N+2.
4. rst_n asserted low mid-ACCESS of a write of 0x0FFF to addr 7 -> ram_wren low immediately, addr 7 unchanged, all outputs 0, next tie goes to A.
5. A issues a read whose ack arrives; A keeps a_req high in N+2 -> treated as a second command: second ack in N+3, two rvalid pulses total.
